// File: rtl/stage_loader.sv
// stage_loader: copies the 30-row stage ROM into the brick map after each
// start pulse. Row reads and brick-map writes overlap under a ready/valid
// handshake, and the non-empty bricks of every accepted row are counted.
// Optional build macro: STAGE_LOADER_COUNT_EN builds the brick counter;
// without it brick_count is tied to zero.
module stage_loader #(
  parameter int ROWS   = 30,
  parameter int DATA_W = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        stage_sel,
  output logic              rom_enable,
  output logic [4:0]        rom_addr,
  output logic [1:0]        rom_stage,
  input  logic [DATA_W-1:0] rom_data,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [8:0]        brick_count
);

  localparam int AW = 5;

  typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] rd_ptr_p0;
  logic          vld_p1;
  logic [AW-1:0] addr_p1;
  logic          accept_start;
  logic          issue;
  logic          accept;
  logic          last_wr;

  // Handshake decode and next-state selection
  always_comb begin
    accept_start = 1'b0;
    issue        = 1'b0;
    accept       = 1'b0;
    last_wr      = 1'b0;
    state_d      = state_q;
    accept_start = (state_q == IDLE) && start;
    // A new read may only go out when the write slot is free or draining now.
    issue   = (state_q == LOAD) && (int'(rd_ptr_p0) < ROWS) && (!vld_p1 || wr_ready);
    accept  = vld_p1 && wr_ready;
    last_wr = accept && (addr_p1 == AW'(ROWS - 1));
    case (state_q)
      IDLE:    if (start)   state_d = LOAD;
      LOAD:    if (last_wr) state_d = FINISH;
      FINISH:               state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // ROM read port: address holds the last issued row while no read goes out
  always_comb begin
    rom_enable = issue;
    rom_addr   = issue ? rd_ptr_p0 : addr_p1;
  end

  // Stage p0 -> p1: read issue feeds the write slot one cycle later
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_ptr_p0 <= '0;
      vld_p1    <= 1'b0;
      addr_p1   <= '0;
      rom_stage <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      done    <= (state_d == FINISH);
      if (accept_start) begin
        rom_stage <= stage_sel;
        rd_ptr_p0 <= '0;
        vld_p1    <= 1'b0;
      end else if (issue) begin
        rd_ptr_p0 <= rd_ptr_p0 + AW'(1);
        vld_p1    <= 1'b1;
        addr_p1   <= rd_ptr_p0;
      end else if (accept) begin
        vld_p1    <= 1'b0;
      end
    end
  end

  assign wr_en   = vld_p1;
  assign wr_addr = addr_p1;
  assign wr_data = rom_data;

`ifdef STAGE_LOADER_COUNT_EN
  localparam int         FIELDS  = DATA_W / 3;
  localparam logic [8:0] CNT_MAX = 9'd300;

  logic [8:0] count_p2;

  // Number of non-empty 3-bit brick codes in one row
  function automatic logic [3:0] bricks_in_row(input logic [DATA_W-1:0] row);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < FIELDS; i++) begin
      if (row[3*i +: 3] != 3'b000) n = n + 4'd1;
    end
    return n;
  endfunction

  // Accumulate with a ceiling at the largest possible map population
  function automatic logic [8:0] sat_add(input logic [8:0] acc, input logic [3:0] inc);
    logic [9:0] sum;
    sum = {1'b0, acc} + {6'd0, inc};
    return (sum > {1'b0, CNT_MAX}) ? CNT_MAX : sum[8:0];
  endfunction

  // Stage p1 -> p2: count bricks of each accepted row
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_p2 <= '0;
    end else if (accept_start) begin
      count_p2 <= '0;
    end else if (accept) begin
      count_p2 <= sat_add(count_p2, bricks_in_row(rom_data));
    end
  end

  assign brick_count = count_p2;
`else
  assign brick_count = '0;
`endif

endmodule

// File: tb/tb_stage_loader.sv
// tb_stage_loader: scoreboard bench for stage_loader. A ROM model feeds the
// DUT; each accepted start queues the 30 rows it must write, and a negedge
// monitor pops and checks every accepted write, stall behaviour and timing.
module tb_stage_loader;
  localparam int ROWS = 30;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  stage_sel;
  logic        rom_enable;
  logic [4:0]  rom_addr;
  logic [1:0]  rom_stage;
  logic [29:0] rom_data;
  logic        wr_en;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [29:0] wr_data;
  logic        busy;
  logic        done;
  logic [8:0]  brick_count;

  always #5 clock = ~clock;

  stage_loader #(.ROWS(ROWS), .DATA_W(30)) dut (
    .clock(clock), .reset(reset), .start(start), .stage_sel(stage_sel),
    .rom_enable(rom_enable), .rom_addr(rom_addr), .rom_stage(rom_stage),
    .rom_data(rom_data), .wr_en(wr_en), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .brick_count(brick_count)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [29:0] data;
  } wr_t;

  logic [29:0] mem [4][ROWS];
  wr_t         expq[$];
  int          tests = 0;
  int          fails = 0;
  int          exp_count = 0;
  int          exp_stage = 0;
  int          stalls = 0;
  int          done_seen = 0;
  int          last_done_n = 0;
  time         te = 0;
  bit          active = 1'b0;
  int          ready_mode = 0;
  int          stall_left = 0;

  // ROM model: registered read, output held while not enabled
  always @(posedge clock) begin
    if (rom_enable && rom_addr < ROWS) rom_data <= mem[rom_stage][rom_addr];
  end

  function automatic int bricks(input logic [29:0] r);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) if (r[3*i +: 3] != 3'b000) n++;
    return n;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // wr_ready driver: always ready, random, or a 3-cycle stall on row 5
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      1: wr_ready = ($urandom_range(3) != 0);
      2: begin
        if (wr_en && wr_addr == 5'd5 && stall_left > 0) begin
          wr_ready = 1'b0;
          stall_left--;
        end else begin
          wr_ready = 1'b1;
        end
      end
      default: wr_ready = 1'b1;
    endcase
  end

  // Monitor: checks the load in progress once per cycle
  always @(negedge clock) begin
    int n;
    if (!reset && active) begin
      n = int'(($time - te + 5) / 10);
      if (n == 1) begin
        check("count_clear", 64'(brick_count), 64'd0);
        check("busy_on", 64'(busy), 64'd1);
      end
      if (rom_enable) begin
        check("rom_addr_range", 64'(rom_addr < ROWS), 64'd1);
        check("rom_stage", 64'(rom_stage), 64'(exp_stage));
      end
      if (wr_en) begin
        check("write_expected", 64'(expq.size() > 0), 64'd1);
        if (expq.size() > 0) begin
          check("wr_addr", 64'(wr_addr), 64'(expq[0].addr));
          check("wr_data", 64'(wr_data), 64'(expq[0].data));
          if (wr_ready) begin
            void'(expq.pop_front());
          end else begin
            stalls++;
            check("stall_rom_enable", 64'(rom_enable), 64'd0);
          end
        end
      end
      if (done) begin
        check("done_cycle", 64'(n), 64'(32 + stalls));
        check("all_rows_written", 64'(expq.size()), 64'd0);
        check("brick_count", 64'(brick_count), 64'(exp_count));
        last_done_n = n;
        done_seen++;
        active = 1'b0;
      end
    end
  end

  task automatic do_start(input int s);
    int k;
    int sum;
    wr_t e;
    k = 0;
    while (busy && k < 200) begin
      @(posedge clock);
      #1;
      k++;
    end
    check("idle_before_start", 64'(busy), 64'd0);
    @(posedge clock);
    #1;
    start     = 1'b1;
    stage_sel = 2'(s);
    @(posedge clock);
    te = $time;
    expq.delete();
    sum = 0;
    for (int i = 0; i < ROWS; i++) begin
      e.addr = 5'(i);
      e.data = mem[s][i];
      expq.push_back(e);
      sum += bricks(mem[s][i]);
    end
`ifdef STAGE_LOADER_COUNT_EN
    exp_count = (sum > 300) ? 300 : sum;
`else
    exp_count = 0;
`endif
    exp_stage = s;
    stalls    = 0;
    active    = 1'b1;
    #1;
    start     = 1'b0;
    stage_sel = 2'($urandom_range(3));
  endtask

  task automatic wait_done(input int limit);
    int seen0;
    int k;
    seen0 = done_seen;
    k = 0;
    while (done_seen == seen0 && k < limit) begin
      @(posedge clock);
      k++;
    end
    check("done_seen", 64'(done_seen != seen0), 64'd1);
    @(negedge clock);
    check("busy_off_after_done", 64'(busy), 64'd0);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_rom_enable", 64'(rom_enable), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);
    check("rst_rom_stage", 64'(rom_stage), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_brick_count", 64'(brick_count), 64'd0);
  endtask

  initial begin
    // ROM contents: random rows with about half the bricks empty, plus the
    // rows whose exact values are known for particular stages.
    for (int s = 0; s < 4; s++) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int f = 0; f < 10; f++) begin
          mem[s][r][3*f +: 3] = ($urandom_range(1) == 1) ? 3'($urandom_range(7, 1)) : 3'b000;
        end
      end
    end
    for (int r = 0; r < ROWS; r++) mem[0][r] = 30'd0;
    mem[0][0]  = 30'o7777777777;
    mem[0][1]  = 30'o1234567123;
    mem[0][2]  = 30'o0001020304;
    mem[2][1]  = 30'b000_000_110_110_110_110_110_110_000_000;
    mem[2][20] = 30'b000_000_000_110_110_110_110_000_000_000;
    mem[3][5]  = 30'b000_000_000_101_011_011_101_000_000_000;

    reset = 1'b1;
    start = 1'b0;
    stage_sel = 2'd0;
    wr_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs();
    reset = 1'b0;

    // Stage 0 with the brick map always ready
    ready_mode = 0;
    do_start(0);
    wait_done(200);
    check("stage0_done_cycle", 64'(last_done_n), 64'd32);

    // Stage 2 with the brick map always ready
    do_start(2);
    wait_done(200);

    // Stage 3 with a 3-cycle stall on row 5
    stall_left = 3;
    ready_mode = 2;
    do_start(3);
    wait_done(200);
    check("stage3_done_cycle", 64'(last_done_n), 64'd35);
    ready_mode = 0;

    // Second start in cycle 10 of a stage-0 load must be ignored
    do_start(0);
    repeat (9) @(posedge clock);
    #1;
    start = 1'b1;
    stage_sel = 2'd1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("ignored_start_stage", 64'(rom_stage), 64'd0);
    wait_done(200);
    check("ignored_start_done_cycle", 64'(last_done_n), 64'd32);

    // Reset in cycle 15 of a load, then a clean stage-1 load
    do_start(2);
    repeat (14) @(posedge clock);
    #3;
    reset  = 1'b1;
    active = 1'b0;
    #1;
    check_reset_outputs();
    expq.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    do_start(1);
    wait_done(200);
    check("after_reset_done_cycle", 64'(last_done_n), 64'd32);

    // Random stages with random back-pressure
    ready_mode = 1;
    for (int it = 0; it < 6; it++) begin
      do_start(int'($urandom_range(3)));
      wait_done(400);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
